// File: rtl/seq_shift_mult.sv
// seq_shift_mult: radix-2 sequential shift-add multiplier, signed or unsigned.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (a, b, is_signed latched on accept)
//   out_valid/out_ready : product handshake, p held until taken
//   busy              : high while iterating over multiplier bits
module seq_shift_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 sgn_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   pp_term;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last;
  logic                 accept;

  always_comb begin
    a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    pp_term = a_ext << cnt_q;
    last    = (cnt_q == CW'(WIDTH - 1));
    acc_d   = acc_q;
    if (b_q[cnt_q]) begin
      // In signed mode the multiplier MSB carries weight -2^(WIDTH-1).
      if (sgn_q && last) begin
        acc_d = acc_q - pp_term;
      end else begin
        acc_d = acc_q + pp_term;
      end
    end
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Acceptance is handled ahead of the state case: it can only fire in IDLE
  // or DONE, which gives the DONE->CALC back-to-back path for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sgn_q   <= is_signed;
      cnt_q   <= '0;
      acc_q   <= '0;
      state_q <= CALC;
    end else begin
      case (state_q)
        CALC: begin
          acc_q <= acc_d;
          if (last) begin
            p_q     <= acc_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_shift_mult.sv
module tb_seq_shift_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv  [2];
  logic [7:0] ai  [2];
  logic [7:0] bi  [2];
  logic       si  [2];
  logic       ori [2];

  logic        ir8, ov8, bz8;
  logic [15:0] p8;
  logic        ir4, ov4, bz4;
  logic [7:0]  p4;

  seq_shift_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8),
    .a(ai[0]), .b(bi[0]), .is_signed(si[0]), .out_valid(ov8),
    .out_ready(ori[0]), .p(p8), .busy(bz8)
  );

  seq_shift_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir4),
    .a(ai[1][3:0]), .b(bi[1][3:0]), .is_signed(si[1]), .out_valid(ov4),
    .out_ready(ori[1]), .p(p4), .busy(bz4)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input bit s);
    longint av, bv;
    logic [63:0] r;
    av = longint'(a) % (longint'(1) << w);
    bv = longint'(b) % (longint'(1) << w);
    if (s && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
    if (s && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    r = 64'(av * bv);
    return r & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Transaction-level timing model: an accepted operation occupies the
  // multiplier for WIDTH cycles, then its product is offered until taken.
  bit          m_calc [2];
  bit          m_done [2];
  int          m_left [2];
  logic [63:0] m_p    [2];
  logic [63:0] m_pend [2];
  int          n_acc  [2];
  int          n_cons [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_calc[i] = 0; m_done[i] = 0; m_left[i] = 0;
      m_p[i] = '0; m_pend[i] = '0; n_acc[i] = 0; n_cons[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ex_rdy;
      int w;
      w = (i == 0) ? 8 : 4;
      ex_rdy = !m_calc[i] && (!m_done[i] || ori[i]);
      if (rst) begin
        m_calc[i] = 0; m_done[i] = 0; m_left[i] = 0; m_p[i] = '0;
      end else if (m_calc[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_calc[i] = 0;
          m_done[i] = 1;
          m_p[i] = m_pend[i];
        end
      end else if (iv[i] && ex_rdy) begin
        if (m_done[i]) n_cons[i]++;
        m_done[i] = 0;
        m_calc[i] = 1;
        m_left[i] = w;
        m_pend[i] = ref_prod(w, ai[i], bi[i], si[i]);
        n_acc[i]++;
      end else if (m_done[i] && ori[i]) begin
        m_done[i] = 0;
        n_cons[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic        o_ir, o_ov, o_bz;
        logic [63:0] o_p;
        string       tag;
        tag  = (i == 0) ? "w8" : "w4";
        o_ir = (i == 0) ? ir8 : ir4;
        o_ov = (i == 0) ? ov8 : ov4;
        o_bz = (i == 0) ? bz8 : bz4;
        o_p  = (i == 0) ? 64'(p8) : 64'(p4);
        check({tag, " in_ready"}, 64'(o_ir), 64'(!m_calc[i] && (!m_done[i] || ori[i])));
        check({tag, " out_valid"}, 64'(o_ov), 64'(m_done[i]));
        check({tag, " busy"}, 64'(o_bz), 64'(m_calc[i]));
        check({tag, " p"}, o_p, m_p[i]);
      end
    end
  end

  // Called one time unit after an accepting edge; counts edges inclusive of
  // that edge until out_valid is seen, and cycles spent busy.
  task automatic wait_done8(output int n, output int nb, output bit got);
    n = 1; nb = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (bz8) nb++;
      if (ov8) got = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("w8 result timeout", 64'(got), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                     input logic [15:0] exp, input int hold, input string nm);
    int n, nb;
    bit got;
    iv[0] = 1; ai[0] = a; bi[0] = b; si[0] = s;
    @(posedge clk); #1;
    iv[0] = 0; ai[0] = ~a; bi[0] = ~b; si[0] = ~s;
    wait_done8(n, nb, got);
    check({nm, " latency"}, 64'(n), 64'd9);
    check({nm, " busy cycles"}, 64'(nb), 64'd8);
    check({nm, " product"}, 64'(p8), 64'(exp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({nm, " held p"}, 64'(p8), 64'(exp));
      check({nm, " held in_ready"}, 64'(ir8), 64'd0);
      check({nm, " held out_valid"}, 64'(ov8), 64'd1);
    end
    ori[0] = 1; #1;
    check({nm, " ready to drain"}, 64'(ir8), 64'd1);
    @(posedge clk); #1;
    ori[0] = 0;
    check({nm, " idle out_valid"}, 64'(ov8), 64'd0);
    check({nm, " idle in_ready"}, 64'(ir8), 64'd1);
  endtask

  initial begin
    int  n, nb, sent, guard;
    bit  got, t;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; ai[i] = '0; bi[i] = '0; si[i] = 0; ori[i] = 0;
    end
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;
    check("reset in_ready", 64'(ir8), 64'd1);
    check("reset out_valid", 64'(ov8), 64'd0);
    check("reset busy", 64'(bz8), 64'd0);
    check("reset p", 64'(p8), 64'd0);
    check("reset w4 p", 64'(p4), 64'd0);

    op8(8'hFF, 8'hFF, 0, 16'hFE01, 0, "u ff*ff");
    op8(8'h80, 8'h80, 1, 16'h4000, 0, "s 80*80");
    op8(8'hFF, 8'h01, 1, 16'hFFFF, 0, "s ff*01");
    op8(8'hFF, 8'h01, 0, 16'h00FF, 0, "u ff*01");
    op8(8'h00, 8'h5A, 0, 16'h0000, 0, "zero");
    op8(8'h03, 8'h05, 0, 16'h000F, 6, "backpressure 3*5");
    op8(8'h7F, 8'h80, 1, 16'hC080, 0, "s 7f*80");

    // back-to-back: 2*2 then 7*9 accepted on the draining edge
    iv[0] = 1; ai[0] = 8'd2; bi[0] = 8'd2; si[0] = 0;
    @(posedge clk); #1;
    iv[0] = 0;
    wait_done8(n, nb, got);
    check("b2b first p", 64'(p8), 64'h4);
    ori[0] = 1; iv[0] = 1; ai[0] = 8'd7; bi[0] = 8'd9; si[0] = 0;
    @(posedge clk); #1;
    iv[0] = 0; ori[0] = 0;
    check("b2b no bubble busy", 64'(bz8), 64'd1);
    wait_done8(n, nb, got);
    check("b2b latency", 64'(n), 64'd9);
    check("b2b product", 64'(p8), 64'h3F);
    ori[0] = 1;
    @(posedge clk); #1;
    ori[0] = 0;

    // reset in the middle of CALC, at counter==4
    iv[0] = 1; ai[0] = 8'h55; bi[0] = 8'h33; si[0] = 0;
    @(posedge clk); #1;
    iv[0] = 0;
    repeat (4) @(posedge clk);
    #1;
    check("mid-calc busy", 64'(bz8), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort out_valid", 64'(ov8), 64'd0);
    check("abort busy", 64'(bz8), 64'd0);
    check("abort p", 64'(p8), 64'd0);
    check("abort in_ready", 64'(ir8), 64'd1);
    op8(8'd2, 8'd3, 0, 16'h0006, 0, "after abort 2*3");

    // reset wins over a simultaneous in_valid
    rst = 1; iv[0] = 1; ai[0] = 8'd5; bi[0] = 8'd5;
    @(posedge clk); #1;
    rst = 0; iv[0] = 0;
    check("rst priority busy", 64'(bz8), 64'd0);
    check("rst priority in_ready", 64'(ir8), 64'd1);

    // WIDTH=4 exhaustive, random consumer backpressure
    sent = 0;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          iv[1] = 1; ai[1] = 8'(a); bi[1] = 8'(b); si[1] = s[0];
          got = 0; guard = 0;
          while (!got && guard < 100) begin
            #1 t = ir4;
            @(posedge clk); #1;
            ori[1] = 1'($urandom_range(0, 1));
            if (t) got = 1;
            guard++;
          end
          if (!got) check("w4 accept timeout", 64'd0, 64'd1);
          sent++;
        end
      end
    end
    iv[1] = 0; ori[1] = 1;
    guard = 0;
    while (n_cons[1] != sent && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("w4 accepted count", 64'(n_acc[1]), 64'd512);
    check("w4 consumed count", 64'(n_cons[1]), 64'd512);
    @(posedge clk); #1;
    check("w4 final out_valid", 64'(ov4), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
